microc_ctrl: RTL

Control unit for the `microc` single-cycle datapath. It decodes the 6-bit `Opcode` and the `z` flag into the datapath controls `s_inc`, `s_inm`, `we`, `wez` and `Op`, and adds a `pc_en` output. A run/halt/single-step sequencer gates execution and provides debug control. An optional performance/status block counts retired instructions and flags illegal opcodes. It sits beside `microc` at the CPU top level and replaces hand-driven control signals.

---
 rtl/microc_pkg.sv | 26 ++
 rtl/microc_decode.sv | 54 +++++
 rtl/microc_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/microc_pkg.sv
// rtl/microc_pkg.sv - shared opcode, ALU and sequencer encodings for the microc control unit
package microc_pkg;

  // Opcode[5:4] class field for the li / ALU register / ALU immediate groups
  localparam logic [1:0] OPC_LI   = 2'b00;
  localparam logic [1:0] OPC_ALUR = 2'b01;
  localparam logic [1:0] OPC_ALUI = 2'b10;

  localparam logic [5:0] OPC_J    = 6'b110000;
  localparam logic [5:0] OPC_JZ   = 6'b110001;
  localparam logic [5:0] OPC_JNZ  = 6'b110010;
  localparam logic [5:0] OPC_NOP  = 6'b111111;
  localparam logic [5:0] OPC_HALT = 6'b111110;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

endpackage

// File: rtl/microc_decode.sv
// rtl/microc_decode.sv - pure combinational opcode/zero-flag decode, ungated
module microc_decode
  import microc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we,
  output logic       wez,
  output logic [2:0] op,
  output logic       halt,
  output logic       illegal
);

  always_comb begin
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we      = 1'b0;
    wez     = 1'b0;
    op      = ALU_PASS;
    halt    = 1'b0;
    illegal = 1'b0;
    case (opcode[5:4])
      OPC_LI: begin
        we    = 1'b1;
        s_inm = 1'b1;
      end
      OPC_ALUR: begin
        we  = 1'b1;
        wez = 1'b1;
        op  = opcode[3:1];
      end
      OPC_ALUI: begin
        we    = 1'b1;
        wez   = 1'b1;
        s_inm = 1'b1;
        op    = opcode[3:1];
      end
      default: begin
        // 11xxxx: control flow group; anything unlisted behaves as nop
        case (opcode)
          OPC_J:    s_inc = 1'b0;
          OPC_JZ:   s_inc = ~z;
          OPC_JNZ:  s_inc = z;
          OPC_NOP:  s_inc = 1'b1;
          OPC_HALT: halt = 1'b1;
          default:  illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/microc_ctrl.sv
// rtl/microc_ctrl.sv - microc control unit: decode gating, run/halt/step FSM, perf block under MICROC_CTRL_PERF_EN
module microc_ctrl
  import microc_pkg::*;
#(
  parameter int AUTORUN = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             running,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  localparam logic   AUTO_BIT  = (AUTORUN != 0);
  localparam state_t RST_STATE = AUTO_BIT ? ST_RUN : ST_HALT;

  state_t     state;
  logic       gate;
  logic       d_s_inc;
  logic       d_s_inm;
  logic       d_we;
  logic       d_wez;
  logic [2:0] d_op;
  logic       d_halt;
  logic       d_illegal;

  microc_decode u_decode (
    .opcode  (Opcode),
    .z       (z),
    .s_inc   (d_s_inc),
    .s_inm   (d_s_inm),
    .we      (d_we),
    .wez     (d_wez),
    .op      (d_op),
    .halt    (d_halt),
    .illegal (d_illegal)
  );

  assign running = (state == ST_RUN) || (state == ST_STEP);

  // Datapath writes are forced safe while reset is held, even when resetting into RUN
  assign gate  = running & ~reset;
  assign s_inc = gate ? d_s_inc : 1'b1;
  assign s_inm = gate & d_s_inm;
  assign we    = gate & d_we;
  assign wez   = gate & d_wez;
  assign Op    = gate ? d_op : ALU_PASS;
  assign pc_en = reset ? AUTO_BIT : (running & ~d_halt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_STATE;
    end else begin
      case (state)
        ST_HALT: begin
          if (stop)       state <= ST_HALT;
          else if (step)  state <= ST_STEP;
          else if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (stop || d_halt) state <= ST_HALT;
        end
        ST_STEP: state <= ST_HALT;
        default: state <= ST_HALT;
      endcase
    end
  end

`ifdef MICROC_CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else if (running) begin
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (d_illegal) illegal_q <= 1'b1;
    end
  end

  assign retired = retired_q;
  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = d_illegal;
  assign retired        = '0;
  assign illegal        = 1'b0;
`endif

endmodule
